// File: rtl/rf_pkg.sv
// Shared types and defaults for the register-file write arbiter.
package rf_pkg;

    localparam int PW_DEF       = 3;
    localparam int PAR_ADDR_DEF = 6;
    localparam int DW           = 8;

    typedef enum logic {INIT, RUN} state_e;
    typedef enum logic {REQ_A, REQ_B} req_e;

endpackage

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-request round-robin arbiter; the pointer names the requester that wins the next contest.
module rr_arb2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    req_e ptr_q, ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        if (en_i) begin
            case (req_i)
                2'b01: gnt_o = 2'b01;
                2'b10: gnt_o = 2'b10;
                2'b11: begin
                    // Contested grant: the loser gets priority next time.
                    gnt_o = (ptr_q == REQ_A) ? 2'b01 : 2'b10;
                    ptr_d = (ptr_q == REQ_A) ? REQ_B : REQ_A;
                end
                default: gnt_o = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= REQ_A;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port controller: round-robin A/B arbitration, registered write port,
// parity-address drop, optional post-reset zero-fill enabled by RF_ARB_INIT_EN.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int PW       = PW_DEF,
    parameter int PAR_ADDR = PAR_ADDR_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    input  logic [PW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [PW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic          rf_wr_en,
    output logic [PW-1:0] rf_wr_addr,
    output logic [DW-1:0] rf_dat,
    output logic          init_busy,
    output logic          drop_pulse
);

`ifdef RF_ARB_INIT_EN
    localparam state_e RST_STATE = INIT;
`else
    localparam state_e RST_STATE = RUN;
`endif

    state_e        state_q, state_d;
    logic          wr_en_q, wr_en_d;
    logic [PW-1:0] addr_q, addr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          drop_q, drop_d;
    logic [1:0]    gnt;
    logic          xfer, par_hit;
    logic [PW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (state_q == RUN),
        .req_i ({b_valid, a_valid}),
        .gnt_o (gnt)
    );

    assign a_ready  = gnt[0];
    assign b_ready  = gnt[1];
    assign xfer     = |gnt;
    assign sel_addr = gnt[1] ? b_addr : a_addr;
    assign sel_data = gnt[1] ? b_data : a_data;
    assign par_hit  = xfer && (sel_addr == PW'(PAR_ADDR));

`ifdef RF_ARB_INIT_EN
    logic [PW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign init_busy = (state_q == INIT);
`else
    assign init_busy = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        dat_d   = dat_q;
        drop_d  = 1'b0;
`ifdef RF_ARB_INIT_EN
        cnt_d   = cnt_q;
`endif
        if (state_q == RUN) begin
            // Parity-address writes are accepted but never reach the register file.
            if (par_hit) begin
                drop_d = 1'b1;
            end else if (xfer) begin
                wr_en_d = 1'b1;
                addr_d  = sel_addr;
                dat_d   = sel_data;
            end
        end
`ifdef RF_ARB_INIT_EN
        else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q != PW'(PAR_ADDR)) begin
                wr_en_d = 1'b1;
                addr_d  = cnt_q;
                dat_d   = '0;
            end
            if (cnt_q == {PW{1'b1}}) state_d = RUN;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            dat_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
            drop_q  <= drop_d;
        end
    end

    assign rf_wr_en   = wr_en_q;
    assign rf_wr_addr = addr_q;
    assign rf_dat     = dat_q;
    assign drop_pulse = drop_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus random traffic against a reference model.
module tb_rf_write_arbiter;

`ifdef RF_ARB_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif
    localparam int PAR = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [2:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_data = '0, b_data = '0;
    logic       a_ready, b_ready, rf_wr_en, init_busy, drop_pulse;
    logic [2:0] rf_wr_addr;
    logic [7:0] rf_dat;

    int total = 0;
    int bad = 0;

    // Register file fed by the DUT write port, and the model's view of its contents.
    logic [7:0] tb_rf [8] = '{default: 8'hEE};
    logic [7:0] m_rf  [8] = '{default: 8'hEE};

    bit         m_init;
    int         m_icnt;
    bit         m_ptr_b;
    logic       m_en, m_drop;
    logic [2:0] m_addr;
    logic [7:0] m_dat;
    logic       last_ea, last_eb, obs_a, obs_b;

    always #5 clk = ~clk;

    always @(posedge clk) if (rf_wr_en === 1'b1) tb_rf[rf_wr_addr] <= rf_dat;

    rf_write_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_valid    (a_valid),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_dat     (rf_dat),
        .init_busy  (init_busy),
        .drop_pulse (drop_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_init  = INIT_EN;
        m_icnt  = 0;
        m_ptr_b = 1'b0;
        m_en    = 1'b0;
        m_drop  = 1'b0;
        m_addr  = '0;
        m_dat   = '0;
        last_ea = 1'b0;
        last_eb = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_wr_en", rf_wr_en, 0);
        chk("rst_addr", rf_wr_addr, 0);
        chk("rst_dat", rf_dat, 0);
        chk("rst_drop", drop_pulse, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_init_busy", init_busy, INIT_EN);
    endtask

    // Called just after a rising edge with the inputs for the coming cycle already driven.
    task automatic cycle();
        logic       ea, eb;
        logic [2:0] wa;
        logic [7:0] wd;
        ea = 1'b0;
        eb = 1'b0;
        if (!m_init) begin
            if (a_valid && b_valid) begin
                ea = !m_ptr_b;
                eb = m_ptr_b;
            end else begin
                ea = a_valid;
                eb = b_valid;
            end
        end
        @(negedge clk);
        obs_a = a_ready;
        obs_b = b_ready;
        chk("a_ready", a_ready, ea);
        chk("b_ready", b_ready, eb);
        chk("ready_onehot", a_ready & b_ready, 0);
        @(posedge clk);
        #1;
        if (m_en) m_rf[m_addr] = m_dat;
        if (m_init) begin
            m_drop = 1'b0;
            if (m_icnt != PAR) begin
                m_en   = 1'b1;
                m_addr = m_icnt[2:0];
                m_dat  = 8'h00;
            end else begin
                m_en = 1'b0;
            end
            if (m_icnt == 7) m_init = 1'b0;
            m_icnt++;
        end else if (ea || eb) begin
            wa = ea ? a_addr : b_addr;
            wd = ea ? a_data : b_data;
            if (wa == 3'(PAR)) begin
                m_en   = 1'b0;
                m_drop = 1'b1;
            end else begin
                m_en   = 1'b1;
                m_drop = 1'b0;
                m_addr = wa;
                m_dat  = wd;
            end
            if (a_valid && b_valid) m_ptr_b = !m_ptr_b;
        end else begin
            m_en   = 1'b0;
            m_drop = 1'b0;
        end
        last_ea = ea;
        last_eb = eb;
        chk("rf_wr_en", rf_wr_en, m_en);
        chk("rf_wr_addr", rf_wr_addr, m_addr);
        chk("rf_dat", rf_dat, m_dat);
        chk("drop_pulse", drop_pulse, m_drop);
        chk("init_busy", init_busy, m_init);
        for (int k = 0; k < 8; k++) chk($sformatf("rf_entry%0d", k), tb_rf[k], m_rf[k]);
    endtask

    // Asynchronous reset in the middle of a cycle, released just after a later rising edge.
    task automatic do_reset();
        #2;
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        model_reset();
        check_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
    endtask

    task automatic set_a(input logic v, input logic [2:0] ad, input logic [7:0] d);
        a_valid = v;
        a_addr  = ad;
        a_data  = d;
    endtask

    task automatic set_b(input logic v, input logic [2:0] ad, input logic [7:0] d);
        b_valid = v;
        b_addr  = ad;
        b_data  = d;
    endtask

    task automatic random_traffic(input int n);
        for (int i = 0; i < n; i++) begin
            if (!a_valid || last_ea) set_a(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
            if (!b_valid || last_eb) set_b(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
            cycle();
        end
    endtask

    initial begin
        model_reset();
        #1;
        check_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Zero-fill (only when built in), then idle.
        for (int i = 0; i < (INIT_EN ? 8 : 1); i++) cycle();
        chk("init_done", init_busy, 0);
        cycle();

        // Solo write from A, then an idle cycle so the register file shows it.
        set_a(1'b1, 3'd2, 8'h5A);
        cycle();
        chk("solo_a_ready", obs_a, 1);
        chk("solo_addr", rf_wr_addr, 2);
        chk("solo_dat", rf_dat, 8'h5A);
        set_a(1'b0, 3'd0, 8'h00);
        cycle();
        chk("solo_rf2", tb_rf[2], 8'h5A);

        // Contention with the pointer still at its reset value.
        set_a(1'b1, 3'd1, 8'h11);
        set_b(1'b1, 3'd3, 8'h22);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("contend_a", obs_a, (i % 2 == 0));
            chk("contend_b", obs_b, (i % 2 == 1));
        end
        set_a(1'b0, 3'd0, 8'h00);
        set_b(1'b0, 3'd0, 8'h00);
        cycle();

        // Parity-address write from B is accepted and dropped.
        set_b(1'b1, 3'd6, 8'hFF);
        cycle();
        chk("par_b_ready", obs_b, 1);
        chk("par_wr_en", rf_wr_en, 0);
        chk("par_drop", drop_pulse, 1);
        set_b(1'b0, 3'd0, 8'h00);
        cycle();
        chk("par_drop_once", drop_pulse, 0);

        // Same address from both: serialised, the later write lands.
        set_a(1'b1, 3'd4, 8'hA4);
        set_b(1'b1, 3'd4, 8'hB4);
        cycle();
        if (last_ea) set_a(1'b0, 3'd0, 8'h00);
        else         set_b(1'b0, 3'd0, 8'h00);
        cycle();
        set_a(1'b0, 3'd0, 8'h00);
        set_b(1'b0, 3'd0, 8'h00);
        cycle();

        random_traffic(120);

        // Reset three cycles after release: mid-INIT when zero-fill is built, mid-RUN otherwise.
        do_reset();
        for (int i = 0; i < 3; i++) cycle();
        set_a(1'b1, 3'd5, 8'h77);
        do_reset();
        for (int i = 0; i < (INIT_EN ? 8 : 1); i++) cycle();
        chk("reinit_done", init_busy, 0);

        random_traffic(120);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
